// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch controller: one tagged word buffer in front of a variable-latency req/ack memory.
// Build option INST_FETCH_PREFETCH_EN adds a next-word prefetch entry and the PREF state.
module inst_fetch_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT = 64,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic              core_en,
  output logic [DATA_W-1:0] core_data,
  output logic              stall_out,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              fetch_err
);
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

`ifdef INST_FETCH_PREFETCH_EN
  typedef enum logic [1:0] {IDLE, REQ, PREF} state_t;
`else
  typedef enum logic [1:0] {IDLE, REQ} state_t;
`endif

  state_t              state, state_nx;
  logic                buf_valid;
  logic [ADDR_W-3:0]   tag;
  logic [DATA_W-1:0]   buf_data;
  logic [CNT_W-1:0]    cnt;
  logic                flush_pend;
  logic                hit_d, hit, miss, done;

  assign hit_d = buf_valid & (tag == core_addr[ADDR_W-1:2]);
  assign done  = mem_ack | (cnt == TO_LAST);

`ifdef INST_FETCH_PREFETCH_EN
  logic                pf_valid, pf_pend, hit_p;
  logic [ADDR_W-3:0]   pf_tag;
  logic [DATA_W-1:0]   pf_data;

  assign hit_p     = pf_valid & (pf_tag == core_addr[ADDR_W-1:2]);
  assign hit       = core_en & (hit_d | hit_p);
  assign core_data = (rst | ~core_en) ? '0 : hit_d ? buf_data : hit_p ? pf_data : '0;
`else
  assign hit       = core_en & hit_d;
  assign core_data = (rst | ~hit) ? '0 : buf_data;
`endif

  assign miss      = core_en & ~hit;
  assign stall_out = ~rst & miss;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (miss) state_nx = REQ;
`ifdef INST_FETCH_PREFETCH_EN
        else if (pf_pend) state_nx = PREF;
`endif
      end
      REQ: if (done) state_nx = IDLE;
`ifdef INST_FETCH_PREFETCH_EN
      PREF: if (done) state_nx = IDLE;
`endif
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid  <= 1'b0;
      tag        <= '0;
      buf_data   <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      fetch_err  <= 1'b0;
      cnt        <= '0;
      flush_pend <= 1'b0;
`ifdef INST_FETCH_PREFETCH_EN
      pf_valid   <= 1'b0;
      pf_pend    <= 1'b0;
      pf_tag     <= '0;
      pf_data    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          cnt        <= '0;
          flush_pend <= 1'b0;
          if (miss) begin
            mem_req  <= 1'b1;
            mem_addr <= {core_addr[ADDR_W-1:2], 2'b00};
          end
`ifdef INST_FETCH_PREFETCH_EN
          // mem_addr still holds the last demand address here
          else if (pf_pend) begin
            mem_req  <= 1'b1;
            mem_addr <= mem_addr + ADDR_W'(4);
            pf_pend  <= 1'b0;
          end
`endif
        end
        REQ: begin
          cnt <= cnt + 1'b1;
          if (flush) flush_pend <= 1'b1;
          if (mem_ack) begin
            buf_data  <= mem_rdata;
            tag       <= mem_addr[ADDR_W-1:2];
            buf_valid <= ~flush_pend;
            mem_req   <= 1'b0;
`ifdef INST_FETCH_PREFETCH_EN
            pf_pend   <= 1'b1;
`endif
          end else if (cnt == TO_LAST) begin
            fetch_err <= 1'b1;
            buf_data  <= NOP_WORD;
            tag       <= mem_addr[ADDR_W-1:2];
            buf_valid <= ~flush_pend;
            mem_req   <= 1'b0;
          end
        end
`ifdef INST_FETCH_PREFETCH_EN
        PREF: begin
          cnt <= cnt + 1'b1;
          if (flush) flush_pend <= 1'b1;
          if (mem_ack) begin
            pf_data  <= mem_rdata;
            pf_tag   <= mem_addr[ADDR_W-1:2];
            pf_valid <= ~flush_pend;
            mem_req  <= 1'b0;
          end else if (cnt == TO_LAST) begin
            pf_valid <= 1'b0;
            mem_req  <= 1'b0;
          end
        end
`endif
        default: mem_req <= 1'b0;
      endcase
      // flush overrides any fill landing on the same edge
      if (flush) begin
        buf_valid <= 1'b0;
`ifdef INST_FETCH_PREFETCH_EN
        pf_valid  <= 1'b0;
`endif
      end
    end
  end
endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl: fills, hits, timeout, flush corner cases, async reset.
module tb_inst_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] core_addr;
  logic        core_en;
  logic [31:0] core_data;
  logic        stall_out;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        fetch_err;

  int total  = 0;
  int passed = 0;
  int nfail  = 0;
  int n;

  inst_fetch_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(64), .NOP_WORD(32'h0)) dut (
    .clk(clk), .rst(rst), .core_addr(core_addr), .core_en(core_en),
    .core_data(core_data), .stall_out(stall_out), .flush(flush),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      nfail++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; core_en = 1'b1; core_addr = 32'h0; flush = 1'b0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    #2;
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_fetch_err", {31'h0, fetch_err}, 32'h0);
    chk("rst_stall", {31'h0, stall_out}, 32'h0);
    chk("rst_core_data", core_data, 32'h0);

    // first miss at 0x0, ack on first REQ cycle
    cyc(); rst = 1'b0; #1;
    chk("miss0_stall_c1", {31'h0, stall_out}, 32'h1);
    chk("miss0_no_req_idle", {31'h0, mem_req}, 32'h0);
    cyc();
    chk("miss0_req", {31'h0, mem_req}, 32'h1);
    chk("miss0_addr", mem_addr, 32'h0);
    chk("miss0_stall_c2", {31'h0, stall_out}, 32'h1);
    mem_ack = 1'b1; mem_rdata = 32'h2401_0005;
    cyc(); mem_ack = 1'b0; mem_rdata = 32'h0; #1;
    chk("miss0_hit_stall", {31'h0, stall_out}, 32'h0);
    chk("miss0_hit_data", core_data, 32'h2401_0005);
    chk("miss0_req_drop", {31'h0, mem_req}, 32'h0);

    // low address bits ignored
    core_addr = 32'h2; #1;
    chk("hit2_data", core_data, 32'h2401_0005);
    chk("hit2_stall", {31'h0, stall_out}, 32'h0);
    cyc();
    chk("hit2_no_req", {31'h0, mem_req}, 32'h0);

    // core_en low
    core_en = 1'b0; #1;
    chk("en0_data", core_data, 32'h0);
    chk("en0_stall", {31'h0, stall_out}, 32'h0);
    core_en = 1'b1;

    // timeout at 0x4
    core_addr = 32'h4; #1;
    chk("to_stall", {31'h0, stall_out}, 32'h1);
    cyc();
    chk("to_req", {31'h0, mem_req}, 32'h1);
    chk("to_addr", mem_addr, 32'h4);
    chk("to_err_pre", {31'h0, fetch_err}, 32'h0);
    n = 1;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (!mem_req) break;
      n++;
    end
    chk("to_req_cycles", 32'(n), 32'd64);
    chk("to_err", {31'h0, fetch_err}, 32'h1);
    chk("to_data_nop", core_data, 32'h0);
    chk("to_stall_after", {31'h0, stall_out}, 32'h0);
    // late ack in IDLE ignored
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    cyc(); mem_ack = 1'b0; #1;
    chk("late_ack_data", core_data, 32'h0);
    chk("late_ack_no_req", {31'h0, mem_req}, 32'h0);

    // flush during REQ for 0x8: fill dropped, re-miss
    core_addr = 32'h8;
    cyc();
    chk("fl_req_addr", mem_addr, 32'h8);
    flush = 1'b1;
    cyc(); flush = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    cyc(); mem_ack = 1'b0; #1;
    chk("fl_remiss_stall", {31'h0, stall_out}, 32'h1);
    chk("fl_remiss_data", core_data, 32'h0);
    chk("fl_gap", {31'h0, mem_req}, 32'h0);
    cyc();
    chk("fl_req2", {31'h0, mem_req}, 32'h1);
    chk("fl_req2_addr", mem_addr, 32'h8);
    // flush coincident with ack
    mem_ack = 1'b1; flush = 1'b1;
    cyc(); mem_ack = 1'b0; flush = 1'b0; #1;
    chk("flack_stall", {31'h0, stall_out}, 32'h1);
    cyc();
    chk("flack_req3", {31'h0, mem_req}, 32'h1);
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_0008;
    cyc(); mem_ack = 1'b0; #1;
    chk("flack_fill", core_data, 32'hCAFE_0008);

    // address change during REQ
    core_addr = 32'hC;
    cyc();
    chk("chg_addr", mem_addr, 32'hC);
    core_addr = 32'h20;
    mem_ack = 1'b1; mem_rdata = 32'hAAAA_000C;
    cyc(); mem_ack = 1'b0; #1;
    chk("chg_newmiss", {31'h0, stall_out}, 32'h1);
    chk("chg_gap", {31'h0, mem_req}, 32'h0);
    core_addr = 32'hC; #1;
    chk("chg_old_filled", core_data, 32'hAAAA_000C);
    core_addr = 32'h20;
    cyc();
    chk("chg_req_new", mem_addr, 32'h20);

    // async reset mid-REQ
    #2 rst = 1'b1; #1;
    chk("arst_req", {31'h0, mem_req}, 32'h0);
    chk("arst_addr", mem_addr, 32'h0);
    chk("arst_stall", {31'h0, stall_out}, 32'h0);
    chk("arst_err", {31'h0, fetch_err}, 32'h0);
    cyc(); rst = 1'b0; core_addr = 32'h0; #1;
    chk("arst_remiss", {31'h0, stall_out}, 32'h1);
    chk("arst_remiss_data", core_data, 32'h0);
    cyc();
    chk("arst_req_again", {31'h0, mem_req}, 32'h1);
    mem_ack = 1'b1; mem_rdata = 32'h0000_1111;
    cyc(); mem_ack = 1'b0;

`ifdef INST_FETCH_PREFETCH_EN
    core_addr = 32'h10;
    cyc();
    chk("pf_dem_addr", mem_addr, 32'h10);
    mem_ack = 1'b1; mem_rdata = 32'hAAAA_0010;
    cyc(); mem_ack = 1'b0; #1;
    chk("pf_dem_hit", core_data, 32'hAAAA_0010);
    cyc();
    chk("pf_req", {31'h0, mem_req}, 32'h1);
    chk("pf_addr", mem_addr, 32'h14);
    mem_ack = 1'b1; mem_rdata = 32'hBBBB_0014;
    cyc(); mem_ack = 1'b0;
    core_addr = 32'h14; #1;
    chk("pf_hit_data", core_data, 32'hBBBB_0014);
    chk("pf_hit_stall", {31'h0, stall_out}, 32'h0);
    cyc();
    chk("pf_no_demand", {31'h0, mem_req}, 32'h0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
